// File: rtl/uart_rx_word_if.sv
// ============================================================================
// uart_rx_word_if : serial input and word-output bundle of uart_rx_word
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

interface uart_rx_word_if;
  logic        srx;
  logic [31:0] rx_word;
  logic        valid;
  logic        err;
  logic        idle;

  // Drives the pin and consumes words (board side / testbench)
  modport master (
    output srx,
    input  rx_word,
    input  valid,
    input  err,
    input  idle
  );

  // Receiver side
  modport slave (
    input  srx,
    output rx_word,
    output valid,
    output err,
    output idle
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_word.sv
// ============================================================================
// uart_rx_word : 8N1 receiver assembling four bytes into a big-endian word
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module uart_rx_word #(
  parameter int CLK_RATE     = 50,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  wire logic     clk,
  input  wire logic     rst,
  uart_rx_word_if.slave rx_bus
);

  localparam int c_CLKS_PER_BIT = CLK_RATE * 1_000_000 / BAUD;
  localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT);
  localparam int c_GAP_LIMIT    = TIMEOUT_BITS * c_CLKS_PER_BIT;
  localparam int c_GAP_W        = $clog2(c_GAP_LIMIT + 1);

  localparam logic [c_CNT_W-1:0] c_HALF     = c_CNT_W'((c_CLKS_PER_BIT - 1) / 2);
  localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(c_CLKS_PER_BIT - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(c_GAP_LIMIT - 1);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_START = 3'd1;
  localparam logic [2:0] c_ST_DATA  = 3'd2;
  localparam logic [2:0] c_ST_STOP  = 3'd3;
  localparam logic [2:0] c_ST_WAITH = 3'd4;

  logic [1:0]         sync_q;
  logic [2:0]         state_q,   state_d;
  logic [c_CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q,   shift_d;
  logic [23:0]        word_sr_q, word_sr_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [31:0]        rx_word_q, rx_word_d;
  logic               valid_q,   valid_d;
  logic               err_q,     err_d;
  logic [c_GAP_W-1:0] gap_q,     gap_d;

  logic w_rxs;
  logic w_start;
  logic w_byte_ok;
  logic w_frame_err;
  logic w_idle;

  assign w_rxs = sync_q[1];

  // State register, bit-level datapath and word registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      state_q    <= c_ST_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      word_sr_q  <= '0;
      byte_cnt_q <= '0;
      rx_word_q  <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      gap_q      <= '0;
    end else begin
      sync_q     <= {sync_q[0], rx_bus.srx};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      word_sr_q  <= word_sr_d;
      byte_cnt_q <= byte_cnt_d;
      rx_word_q  <= rx_word_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      gap_q      <= gap_d;
    end
  end

  // Next-state logic of the bit FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    w_start     = 1'b0;
    w_byte_ok   = 1'b0;
    w_frame_err = 1'b0;
    case (state_q)
      c_ST_IDLE: begin
        if (!w_rxs) begin
          w_start = 1'b1;
          state_d = c_ST_START;
          cnt_d   = '0;
        end
      end
      c_ST_START: begin
        if (cnt_q == c_HALF) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = w_rxs ? c_ST_IDLE : c_ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_ST_DATA: begin
        if (cnt_q == c_LAST) begin
          cnt_d     = '0;
          shift_d   = {w_rxs, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = c_ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_ST_STOP: begin
        if (cnt_q == c_LAST) begin
          cnt_d = '0;
          if (w_rxs) begin
            w_byte_ok = 1'b1;
            state_d   = c_ST_IDLE;
          end else begin
            w_frame_err = 1'b1;
            state_d     = c_ST_WAITH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_ST_WAITH: begin
        if (w_rxs) state_d = c_ST_IDLE;
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  // Word assembly, inter-byte timeout and status outputs
  always_comb begin
    word_sr_d  = word_sr_q;
    byte_cnt_d = byte_cnt_q;
    rx_word_d  = rx_word_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    gap_d      = '0;
    w_idle     = (state_q == c_ST_IDLE) && (byte_cnt_q == 2'd0);

    // A start detected on the expiry clock suppresses the timeout
    if (!w_start && (state_q == c_ST_IDLE) && (byte_cnt_q != 2'd0)) begin
      if (gap_q == c_GAP_LAST) begin
        byte_cnt_d = '0;
        word_sr_d  = '0;
        err_d      = 1'b1;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end

    if (w_byte_ok) begin
      word_sr_d  = {word_sr_q[15:0], shift_q};
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (byte_cnt_q == 2'd3) begin
        rx_word_d = {word_sr_q, shift_q};
        valid_d   = 1'b1;
      end
    end

    if (w_frame_err) begin
      byte_cnt_d = '0;
      word_sr_d  = '0;
      err_d      = 1'b1;
    end
  end

  assign rx_bus.rx_word = rx_word_q;
  assign rx_bus.valid   = valid_q;
  assign rx_bus.err     = err_q;
  assign rx_bus.idle    = w_idle;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_word.sv
// ============================================================================
// tb_uart_rx_word : directed scoreboard bench for uart_rx_word
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_word;

  localparam int CPB = 10;

  logic clk;
  logic rst;
  int   checks    = 0;
  int   failures  = 0;
  int   valid_cnt = 0;
  int   err_cnt   = 0;
  logic [31:0] exp_q[$];

  uart_rx_word_if bus ();

  uart_rx_word #(
    .CLK_RATE    (1),
    .BAUD        (100000),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic line(input logic b, input int n);
    bus.srx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(d[i], CPB);
    line(stop_bit, CPB);
    bus.srx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_q.push_back(w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  // Output monitor: scoreboard pop on valid, pulse accounting
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid) begin
        logic [31:0] exp_w;
        valid_cnt++;
        check("err_with_valid", {31'b0, bus.err}, 32'd0);
        check("sb_has_entry", {31'b0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check("rx_word", bus.rx_word, exp_w);
        end
      end
      if (bus.err) err_cnt++;
    end
  end

  initial begin
    int v0, e0, err_at;
    rst     = 1'b1;
    bus.srx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rx_word", bus.rx_word, 32'd0);
    check("rst_valid", {31'b0, bus.valid}, 32'd0);
    check("rst_err", {31'b0, bus.err}, 32'd0);
    check("rst_idle", {31'b0, bus.idle}, 32'd1);
    rst = 1'b0;
    line(1'b1, 5);

    // Single word
    send_word(32'hDEADBEEF);
    line(1'b1, 5);
    check("w1_valids", valid_cnt, 1);
    check("w1_errs", err_cnt, 0);
    check("w1_idle", {31'b0, bus.idle}, 32'd1);

    // Two back-to-back words, first held in between
    send_word(32'h12345678);
    check("hold_12345678", bus.rx_word, 32'h12345678);
    send_word(32'h9ABCDEF0);
    line(1'b1, 5);
    check("w2_valids", valid_cnt, 3);
    check("w2_errs", err_cnt, 0);

    // Inter-byte timeout discards a partial word
    v0 = valid_cnt; e0 = err_cnt; err_at = -1;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (bus.err && err_at < 0) err_at = i;
    end
    check("to_err_seen", {31'b0, err_at >= 190 && err_at <= 210}, 32'd1);
    check("to_err_count", err_cnt - e0, 1);
    check("to_idle", {31'b0, bus.idle}, 32'd1);
    send_word(32'hCAFEBABE);
    line(1'b1, 5);
    check("to_valids", valid_cnt - v0, 1);
    check("to_errs_after", err_cnt - e0, 1);

    // Framing error followed by a held-low break
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'hAA, 1'b0);
    line(1'b0, 100);
    line(1'b1, 20);
    check("fe_err_count", err_cnt - e0, 1);
    check("fe_no_valid", valid_cnt - v0, 0);
    check("fe_idle", {31'b0, bus.idle}, 32'd1);
    send_word(32'h01020304);
    line(1'b1, 5);
    check("fe_valids", valid_cnt - v0, 1);
    check("fe_errs_after", err_cnt - e0, 1);

    // Short glitch while idle
    v0 = valid_cnt; e0 = err_cnt;
    line(1'b0, 3);
    line(1'b1, 20);
    check("gl_errs", err_cnt - e0, 0);
    check("gl_valids", valid_cnt - v0, 0);
    check("gl_idle", {31'b0, bus.idle}, 32'd1);

    // Reset in the middle of the second byte of a word
    send_byte(8'h11, 1'b1);
    line(1'b0, CPB);
    line(1'b1, 4 * CPB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    line(1'b1, 5 * CPB + 20);
    check("mr_idle", {31'b0, bus.idle}, 32'd1);
    check("mr_rx_word", bus.rx_word, 32'd0);
    send_word(32'hA55AFF00);
    line(1'b1, 5);
    check("mr_valids", valid_cnt - v0, 1);
    check("mr_errs", err_cnt - e0, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
